regfile_writeback_arbiter: RTL
==============================

Name: regfile_writeback_arbiter

Overview:
- Write-side counterpart to the 32x64 register file read ports.
- Collects destination-register results from two producers, the ALU and the load unit, through valid/ready handshakes.
- Buffers each producer in a small FIFO and arbitrates them onto the single register-file write port (one write per cycle).
- Keeps a 32-bit pending-write scoreboard that the issue stage reads to stall RAW hazards.

Parameters:
- XLEN, 64, data width of a register.
- DEPTH, 2, entries per producer FIFO (power of two, >=2).
- STARVE_LIMIT, 4, consecutive cycles a ready ALU head may lose arbitration before it is forced to win once.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- alu_valid_i  in  1  ALU result valid
- alu_ready_o  out  1  ALU FIFO not full
- alu_addr_i  in  5  ALU destination register
- alu_data_i  in  XLEN  ALU result
- ld_valid_i  in  1  load result valid
- ld_ready_o  out  1  load FIFO not full
- ld_addr_i  in  5  load destination register
- ld_data_i  in  XLEN  load data
- rsv_valid_i  in  1  issue stage reserves a destination
- rsv_addr_i  in  5  reserved register
- write_en_o  out  1  register-file write enable
- write_addr_o  out  5  register-file write address
- write_data_o  out  XLEN  register-file write data
- busy_mask_o  out  32  bit i set = write to xi pending

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high.
- Reset state:
  - FIFOs empty.
  - alu_ready_o=1 and ld_ready_o=1 in the cycle after reset.
  - write_en_o=0, write_addr_o=0, write_data_o=0.
  - busy_mask_o=0.
  - Starvation counter=0.
- Reset mid-operation discards all buffered entries and reservations. No write is issued in the reset cycle.
- Handshake:
  - A transfer occurs when valid&ready is high on the rising edge.
  - ready depends only on FIFO occupancy (not on valid). ready=0 exactly when the FIFO holds DEPTH entries.
  - A FIFO that is full at cycle start does not accept, even if it pops that cycle (no same-cycle pass-through when full).
- Latency:
  - An entry accepted at edge N into an empty FIFO can appear on write_* after edge N+1 (registered output, 1 cycle).
  - There is no combinational path from the inputs to write_*.
- Arbitration (per cycle, among non-empty FIFO heads):
  - Load wins by default.
  - If the ALU head has lost STARVE_LIMIT consecutive cycles, the ALU wins and the counter clears.
  - The counter clears whenever the ALU wins or the ALU FIFO is empty.
  - The winner pops.
  - write_en_o=1 with the winner's addr/data on the next cycle; otherwise write_en_o=0. Addr and data hold their last values when write_en_o=0.
- x0 handling:
  - An entry with addr 0 is accepted and popped normally but produces write_en_o=0.
  - It still counts as an arbitration win.
- Ordering:
  - Entries within one FIFO are written in acceptance order.
  - Cross-producer ordering to the same register is not enforced. The issue stage must not reserve a register whose busy bit is set.
- Scoreboard:
  - rsv_valid_i sets busy[rsv_addr_i] on the next edge.
  - Issuing a write (write_en_o rising for addr a) clears busy[a] on the same edge that write_en_o goes high.
  - If a set and a clear target the same register on the same edge, the set wins.
  - busy_mask_o[0] is always 0, and reservations of x0 are ignored.
  - Popping an entry whose busy bit is already 0 is legal and has no effect.
- Simultaneous events:
  - Both producers may push in the same cycle.
  - A push and a pop on the same FIFO in the same cycle keep occupancy unchanged.

Decomposition:
- Shared package holds:
  - XLEN_DEFAULT=64
  - REG_ADDR_W=5
  - NUM_REGS=32
  - REG_ZERO=5'd0
  - A packed wb_entry_t {addr[4:0], data[XLEN-1:0]}
- One sub-module, regfile_wb_fifo: synchronous FIFO of wb_entry_t with push/pop, full/empty, and wrap-around pointers plus an extra wrap bit. Instantiated twice.
- Arbitration, the starvation counter, and the scoreboard live in the top level.

Test Plan:
- Reset, then ALU push {x5, 0x1234} at cycle 1 -> write_en_o=1, addr 5, data 0x1234 at cycle 2. busy[5] was set by rsv at cycle 0 and clears at cycle 2.
- ALU {x3, 0xA} and load {x4, 0xB} pushed in the same cycle -> writes x4=0xB then x3=0xA on consecutive cycles. Both readies stay 1.
- Load pushes continuously with DEPTH=2 while ALU holds {x7, 0x77} -> ALU wins on the 5th arbitration cycle. The load FIFO fills and ld_ready_o=0 until it drains.
- Push {x0, 0xDEAD} -> accepted and popped. write_en_o stays 0, busy_mask_o[0]=0. A following {x1, 0x1} writes on the next cycle.
- rsv x9 on the same edge that the x9 write issues -> busy[9]=1 afterwards (set wins).
- Three ALU entries buffered, then rst_i asserted for 1 cycle -> no writes follow, busy_mask_o=0, both readies=1.

Source files
------------

// File: rtl/regfile_writeback_arbiter_pkg.sv
// rtl/regfile_writeback_arbiter_pkg.sv - shared types and constants for the register-file writeback path
package regfile_writeback_arbiter_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One buffered result: destination register and the value to write there.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]   addr;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// rtl/regfile_wb_fifo.sv - small synchronous FIFO of writeback entries
module regfile_wb_fifo
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // The extra top bit tells a full FIFO apart from an empty one when the index bits match.
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_o = (wr_ptr == rd_ptr);

  // Fullness is judged at cycle start, so a full FIFO never accepts even while popping.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_o = mem[rd_ptr[AW-1:0]];

  // Advance read and write pointers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Store accepted entries; storage needs no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - arbitrates ALU and load results onto the register-file write port
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [REG_ADDR_W-1:0] alu_addr_i,
  input  logic [XLEN-1:0]       alu_data_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [REG_ADDR_W-1:0] ld_addr_i,
  input  logic [XLEN-1:0]       ld_data_i,
  input  logic                  rsv_valid_i,
  input  logic [REG_ADDR_W-1:0] rsv_addr_i,
  output logic                  write_en_o,
  output logic [REG_ADDR_W-1:0] write_addr_o,
  output logic [XLEN-1:0]       write_data_o,
  output logic [NUM_REGS-1:0]   busy_mask_o
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  // Entry layout follows the instance's data width.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } entry_t;

  entry_t              alu_in;
  entry_t              ld_in;
  entry_t              alu_head;
  entry_t              ld_head;
  entry_t              win_entry;
  logic                alu_full;
  logic                alu_empty;
  logic                ld_full;
  logic                ld_empty;
  logic                alu_win;
  logic                ld_win;
  logic                win_is_write;
  logic [CW-1:0]       starve_cnt;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_next;

  assign alu_in = '{addr: alu_addr_i, data: alu_data_i};
  assign ld_in  = '{addr: ld_addr_i,  data: ld_data_i};

  regfile_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_alu_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (alu_valid_i),
    .push_data_i (alu_in),
    .pop_i       (alu_win),
    .head_o      (alu_head),
    .full_o      (alu_full),
    .empty_o     (alu_empty)
  );

  regfile_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ld_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (ld_valid_i),
    .push_data_i (ld_in),
    .pop_i       (ld_win),
    .head_o      (ld_head),
    .full_o      (ld_full),
    .empty_o     (ld_empty)
  );

  // Ready reflects occupancy only, never the producer's valid.
  assign alu_ready_o = !alu_full;
  assign ld_ready_o  = !ld_full;

  // Pick one head per cycle: load by default, ALU when alone or once it has starved long enough.
  always_comb begin
    alu_win = 1'b0;
    ld_win  = 1'b0;
    if (!alu_empty && (ld_empty || (starve_cnt >= STARVE_MAX))) begin
      alu_win = 1'b1;
    end else if (!ld_empty) begin
      ld_win = 1'b1;
    end
  end

  assign win_entry    = alu_win ? alu_head : ld_head;
  assign win_is_write = (alu_win || ld_win) && (win_entry.addr != REG_ZERO);

  // Count consecutive cycles a waiting ALU head loses to the load unit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (alu_empty || alu_win) begin
      starve_cnt <= '0;
    end else if (ld_win) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Register the write port; an x0 win consumes the slot but writes nothing, and addr/data hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_en_o   <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
    end else begin
      write_en_o <= win_is_write;
      if (win_is_write) begin
        write_addr_o <= win_entry.addr;
        write_data_o <= win_entry.data;
      end
    end
  end

  // Pending-write mask update: clear on write issue, then apply the reservation so a same-register set wins.
  always_comb begin
    busy_next = busy_q;
    if (win_is_write) busy_next[win_entry.addr] = 1'b0;
    if (rsv_valid_i)  busy_next[rsv_addr_i]     = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Hold the pending-write mask; reset drops every reservation.
  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_next;
  end

  assign busy_mask_o = busy_q;

endmodule
